// File: rtl/izh_neuron_update_if.sv
`default_nettype none
// ============================================================================
//  Module   : izh_neuron_update_if
//  Purpose  : Bundles the izh_neuron_update request/response signals and its
//             link to the shared fixed_mult stage.
//  Modports : slave  - neuron update sequencer (drives mult_a/mult_b, results)
//             master - host / environment (drives start, operands, mult_ab)
//  Signals  : start, v/u/i/a/b/c/d_in  - step request and operands
//             mult_a, mult_b           - multiplier operands
//             mult_ab, mult_clip_*     - multiplier product and status flags
//             v_out, u_out, spike      - step results
//             clip_int, clip_frac      - sticky saturation flags
//             busy, done               - sequencer status
//  Revision : 1.0  initial release
// ============================================================================
interface izh_neuron_update_if #(
    parameter int W = 17
) ();
    logic         start;
    logic [W-1:0] v_in;
    logic [W-1:0] u_in;
    logic [W-1:0] i_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] c_in;
    logic [W-1:0] d_in;
    logic [W-1:0] mult_a;
    logic [W-1:0] mult_b;
    logic [W-1:0] mult_ab;
    logic         mult_clip_int;
    logic         mult_clip_frac;
    logic [W-1:0] v_out;
    logic [W-1:0] u_out;
    logic         spike;
    logic         clip_int;
    logic         clip_frac;
    logic         busy;
    logic         done;

    modport slave (
        input  start, v_in, u_in, i_in, a_in, b_in, c_in, d_in,
        input  mult_ab, mult_clip_int, mult_clip_frac,
        output mult_a, mult_b,
        output v_out, u_out, spike, clip_int, clip_frac, busy, done
    );

    modport master (
        output start, v_in, u_in, i_in, a_in, b_in, c_in, d_in,
        output mult_ab, mult_clip_int, mult_clip_frac,
        input  mult_a, mult_b,
        input  v_out, u_out, spike, clip_int, clip_frac, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/izh_neuron_update.sv
`default_nettype none
// ============================================================================
//  Module   : izh_neuron_update
//  Purpose  : One Izhikevich neuron step per accepted start, using an external
//             shared fixed-point multiplier:
//               v' = v + dt*(0.04v^2 + 5v + 140 - u + I)
//               u' = u + dt*a*(b*v - u),          dt = 2^-DT_SHIFT
//             If v' >= V_PEAK the neuron spikes: v' = c, u' = u' + d.
//  Ports    : clk, rst          - clock (rising edge), sync active-high reset
//             nif (slave)       - start/operands in, multiplier link,
//                                 v_out/u_out/spike/clip flags/busy/done out
//  Revision : 1.0  initial release
// ============================================================================
module izh_neuron_update #(
    parameter int           W        = 17,
    parameter int           FRAC     = 8,
    parameter int           MULT_LAT = 1,
    parameter int           DT_SHIFT = 1,
    parameter logic [W-1:0] K004     = 17'h0000A,
    parameter logic [W-1:0] K140     = 17'h08C00,
    parameter logic [W-1:0] V_PEAK   = 17'h01E00
) (
    input  wire logic             clk,
    input  wire logic             rst,
    izh_neuron_update_if.slave    nif
);

    // Extended width for intermediate sums: the five-term dv sum needs 3
    // guard bits above the data width.
    localparam int XW = W + 3;
    localparam int CW = $clog2(MULT_LAT + 2);

    localparam logic [W-1:0]         c_max     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         c_min     = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [XW-1:0] c_xmax    = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] c_xmin    = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [CW-1:0]        c_cnt_last = CW'(MULT_LAT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M1   = 3'd1,
        S_M2   = 3'd2,
        S_M3   = 3'd3,
        S_M4   = 3'd4,
        S_ACC  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Fixed-point helpers
    // ------------------------------------------------------------------
    function automatic logic signed [XW-1:0] sx(input logic [W-1:0] x);
        return {{(XW-W){x[W-1]}}, x};
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [XW-1:0] x);
        if (x > c_xmax) begin
            return c_max;
        end else if (x < c_xmin) begin
            return c_min;
        end
        return x[W-1:0];
    endfunction

    function automatic logic ovf(input logic signed [XW-1:0] x);
        return (x > c_xmax) || (x < c_xmin);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [CW-1:0] r_cnt;

    logic [W-1:0]  r_v, r_u, r_i, r_a, r_b, r_c, r_d;
    logic [W-1:0]  r_t2, r_t4;
    logic [W-1:0]  r_res_v, r_res_u;
    logic          r_res_spk;

    logic [W-1:0]  r_mult_a, r_mult_b;
    logic [W-1:0]  r_v_out, r_u_out;
    logic          r_spike, r_clip_int, r_clip_frac, r_busy, r_done;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                 w_in_mult;
    logic                 w_cap;
    logic signed [XW-1:0] w_m4_sum, w_5v_sum, w_dv_sum, w_vn_sum, w_un_sum, w_ud_sum;
    logic [W-1:0]         w_m4_op, w_5v, w_dv, w_vn, w_un, w_ud;
    logic                 w_spk, w_acc_clip;

    assign w_in_mult = (r_state == S_M1) || (r_state == S_M2) ||
                       (r_state == S_M3) || (r_state == S_M4);
    // Product is sampled on the last cycle of each multiply slot.
    assign w_cap     = w_in_mult && (r_cnt == c_cnt_last);

    // Second M4 operand is built straight from the M3 product (t3) as it is
    // captured, so the M4 operands can be driven on the M3->M4 edge.
    assign w_m4_sum = sx(nif.mult_ab) - sx(r_u);
    assign w_m4_op  = sat(w_m4_sum);

    assign w_5v_sum = (sx(r_v) <<< 2) + sx(r_v);
    assign w_5v     = sat(w_5v_sum);

    assign w_dv_sum = sx(r_t2) + sx(w_5v) + sx(K140) - sx(r_u) + sx(r_i);
    assign w_dv     = sat(w_dv_sum);

    assign w_vn_sum = sx(r_v) + (sx(w_dv) >>> DT_SHIFT);
    assign w_vn     = sat(w_vn_sum);

    assign w_un_sum = sx(r_u) + (sx(r_t4) >>> DT_SHIFT);
    assign w_un     = sat(w_un_sum);

    assign w_spk    = $signed(w_vn) >= $signed(V_PEAK);

    assign w_ud_sum = sx(w_un) + sx(r_d);
    assign w_ud     = sat(w_ud_sum);

    // The u+d clamp only matters when the spike path actually uses it.
    assign w_acc_clip = ovf(w_5v_sum) | ovf(w_dv_sum) | ovf(w_vn_sum) |
                        ovf(w_un_sum) | (w_spk & ovf(w_ud_sum));

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_v         <= '0;
            r_u         <= '0;
            r_i         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_t2        <= '0;
            r_t4        <= '0;
            r_res_v     <= '0;
            r_res_u     <= '0;
            r_res_spk   <= 1'b0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_v_out     <= '0;
            r_u_out     <= '0;
            r_spike     <= 1'b0;
            r_clip_int  <= 1'b0;
            r_clip_frac <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_in_mult) begin
                r_cnt <= w_cap ? '0 : r_cnt + CW'(1);
            end

            if (w_cap) begin
                r_clip_frac <= r_clip_frac | nif.mult_clip_frac;
                r_clip_int  <= r_clip_int | nif.mult_clip_int |
                               ((r_state == S_M3) && ovf(w_m4_sum));
            end

            case (r_state)
                S_IDLE: begin
                    if (nif.start) begin
                        r_v         <= nif.v_in;
                        r_u         <= nif.u_in;
                        r_i         <= nif.i_in;
                        r_a         <= nif.a_in;
                        r_b         <= nif.b_in;
                        r_c         <= nif.c_in;
                        r_d         <= nif.d_in;
                        r_clip_int  <= 1'b0;
                        r_clip_frac <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_mult_a    <= K004;
                        r_mult_b    <= nif.v_in;
                        r_state     <= S_M1;
                    end
                end
                S_M1: begin
                    if (w_cap) begin        // t1 = K004*v -> next t1*v
                        r_mult_a <= nif.mult_ab;
                        r_mult_b <= r_v;
                        r_state  <= S_M2;
                    end
                end
                S_M2: begin
                    if (w_cap) begin        // t2 = 0.04 v^2 -> next b*v
                        r_t2     <= nif.mult_ab;
                        r_mult_a <= r_b;
                        r_mult_b <= r_v;
                        r_state  <= S_M3;
                    end
                end
                S_M3: begin
                    if (w_cap) begin        // t3 = b*v -> next a*sat(t3-u)
                        r_mult_a <= r_a;
                        r_mult_b <= w_m4_op;
                        r_state  <= S_M4;
                    end
                end
                S_M4: begin
                    if (w_cap) begin
                        r_t4     <= nif.mult_ab;
                        r_mult_a <= '0;
                        r_mult_b <= '0;
                        r_state  <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_res_v    <= w_spk ? r_c  : w_vn;
                    r_res_u    <= w_spk ? w_ud : w_un;
                    r_res_spk  <= w_spk;
                    r_clip_int <= r_clip_int | w_acc_clip;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    // Results and done are published on the DONE exit edge.
                    r_v_out <= r_res_v;
                    r_u_out <= r_res_u;
                    r_spike <= r_res_spk;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign nif.mult_a    = r_mult_a;
    assign nif.mult_b    = r_mult_b;
    assign nif.v_out     = r_v_out;
    assign nif.u_out     = r_u_out;
    assign nif.spike     = r_spike;
    assign nif.clip_int  = r_clip_int;
    assign nif.clip_frac = r_clip_frac;
    assign nif.busy      = r_busy;
    assign nif.done      = r_done;

endmodule
`default_nettype wire
